// File: rtl/controls_pkg.sv
// controls_pkg: shared jump/branch encodings and datapath width default
package controls_pkg;
    localparam int DEFAULT_XLEN = 32;
    localparam logic [2:0] JMP_NONE = 3'd0;
    localparam logic [2:0] JMP_JAL  = 3'd1;
    localparam logic [2:0] JMP_JALR = 3'd2;
    localparam logic [2:0] JMP_BEQ  = 3'd3;
    localparam logic [2:0] JMP_BNE  = 3'd4;
    localparam logic [2:0] JMP_BLT  = 3'd5;
    localparam logic [2:0] JMP_BGT  = 3'd6;
endpackage

// File: rtl/branch_resolve.sv
// branch_resolve: decides whether the next PC is pc-relative, register-indirect or sequential
module branch_resolve
    import controls_pkg::*;
(
    input  logic [2:0] branch_type,
    input  logic       alu_zero,
    input  logic       alu_neg,
    output logic       take_rel,
    output logic       take_abs
);
    // unknown or reserved encodings fall through to sequential fetch
    always_comb begin
        take_rel = 1'b0;
        take_abs = 1'b0;
        case (branch_type)
            JMP_JAL:  take_rel = 1'b1;
            JMP_JALR: take_abs = 1'b1;
            JMP_BEQ:  take_rel = alu_zero;
            JMP_BNE:  take_rel = !alu_zero;
            JMP_BLT:  take_rel = alu_neg;
            JMP_BGT:  take_rel = !alu_neg;
            default:  ;
        endcase
    end
endmodule

// File: rtl/pc_calc.sv
// pc_calc: program-counter register with next-PC selection and pc+4 return address
module pc_calc
    import controls_pkg::*;
#(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [2:0]      branch_type,
    input  logic [XLEN-1:0] pc_offset,
    input  logic [XLEN-1:0] target_pc,
    input  logic            alu_zero,
    input  logic            alu_neg,
    input  logic            stay,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] return_pc
);
    logic            take_rel;
    logic            take_abs;
    logic [XLEN-1:0] next_pc;

    branch_resolve u_resolve (
        .branch_type(branch_type),
        .alu_zero(alu_zero),
        .alu_neg(alu_neg),
        .take_rel(take_rel),
        .take_abs(take_abs)
    );

    assign return_pc = pc + XLEN'(4);
    // JALR targets are forced to even addresses
    assign next_pc = take_abs ? {target_pc[XLEN-1:1], 1'b0} : take_rel ? pc + pc_offset : return_pc;

    // rstn is an active-high synchronous reset despite its name
    always_ff @(posedge clk) begin
        if (rstn)
            pc <= RESET_PC;
        else if (!stay)
            pc <= next_pc;
    end
endmodule

// File: tb/tb_pc_calc.sv
// tb_pc_calc: scoreboard bench with a reference PC model and directed plus random stimulus
module tb_pc_calc;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [2:0]  branch_type = 3'd0;
    logic [31:0] pc_offset = '0;
    logic [31:0] target_pc = '0;
    logic        alu_zero = 1'b0;
    logic        alu_neg = 1'b0;
    logic        stay = 1'b0;
    logic [31:0] pc;
    logic [31:0] return_pc;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_pc = '0;
    logic [31:0] sb[$];
    bit done = 1'b0;

    pc_calc dut (
        .clk(clk),
        .rstn(rstn),
        .branch_type(branch_type),
        .pc_offset(pc_offset),
        .target_pc(target_pc),
        .alu_zero(alu_zero),
        .alu_neg(alu_neg),
        .stay(stay),
        .pc(pc),
        .return_pc(return_pc)
    );

    always #5 clk = ~clk;

    // reference: what the PC must become given the current PC and this cycle's controls
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input int bt, input logic [31:0] off,
                                             input logic [31:0] tgt, input bit z, input bit n);
        bit taken;
        taken = (bt == 1) || (bt == 3 && z) || (bt == 4 && !z) || (bt == 5 && n) || (bt == 6 && !n);
        if (bt == 2) return tgt & 32'hFFFF_FFFE;
        return taken ? cur + off : cur + 32'd4;
    endfunction

    task automatic step(input bit r, input bit s, input int bt, input logic [31:0] off,
                        input logic [31:0] tgt, input bit z, input bit n);
        @(negedge clk);
        rstn = r;
        stay = s;
        branch_type = 3'(bt);
        pc_offset = off;
        target_pc = tgt;
        alu_zero = z;
        alu_neg = n;
        model_pc = r ? 32'h0 : s ? model_pc : ref_next(model_pc, bt, off, tgt, z, n);
        sb.push_back(model_pc);
        @(posedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        logic [31:0] exp;
        #1;
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            check("pc", pc, exp);
            check("return_pc", return_pc, exp + 32'd4);
        end
    end

    initial begin
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 12, 0, 0, 0);
        step(0, 0, 1, 12, 0, 0, 0);
        step(0, 0, 3, 12, 0, 1, 0);
        step(0, 0, 4, 12, 0, 1, 0);
        step(0, 0, 5, 12, 0, 0, 1);
        step(0, 0, 6, 12, 0, 0, 1);
        step(0, 0, 6, 12, 0, 0, 0);
        step(0, 0, 2, 12, 32'hAD, 1, 1);
        repeat (3) step(0, 1, 1, 12, 0, 0, 0);
        step(1, 1, 1, 12, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 40, 0, 0, 0);
        step(1, 0, 1, 12, 0, 0, 0);
        step(0, 0, 2, 0, 32'hFFFF_FFFC, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 16, 0, 0, 0);
        step(0, 0, 1, 32'hFFFF_FFF8, 0, 0, 0);
        step(0, 0, 7, 100, 32'h40, 1, 1);
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7),
                 $urandom, $urandom, 1'($urandom), 1'($urandom));
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pc_calc.md
Name: pc_calc

Overview:
- Program-counter register and next-PC logic for the single-cycle RISC-V core.
- Holds the current PC and selects the next PC each cycle from one of three sources:
  - sequential (pc+4)
  - PC-relative branch or jump target (pc+pc_offset)
  - register-indirect target for JALR
- The branch decision uses the branch type from the control decoder and the ALU zero and negative flags.
- Also supplies return_pc (pc+4) to the register-file write-back path for JAL/JALR.

Parameters:
- XLEN, 32, datapath/PC width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rstn  in  1  reset: one clock; reset is synchronous and active-high (rstn=1 resets on the next rising clk edge).
- branch_type  in  3  jump/branch selector, JMP_* encoding from the shared package.
- pc_offset  in  XLEN  sign-extended immediate offset from the decoder (B/J-type).
- target_pc  in  XLEN  absolute JALR target (rs1+imm, computed by the ALU).
- alu_zero  in  1  ALU result == 0 (comparison rs1-rs2).
- alu_neg  in  1  ALU comparison says rs1 < rs2 (signed).
- stay  in  1  stall: hold PC this cycle.
- pc  out  XLEN  current program counter (registered).
- return_pc  out  XLEN  pc+4, combinational.

Behaviour:
- Reset and stall:
  - rstn=1 at a rising edge loads pc=RESET_PC, regardless of all other inputs. Reset has priority over stay.
  - return_pc follows pc combinationally, so it reads RESET_PC+4 after reset.
  - Otherwise, stay=1 holds pc unchanged.
  - Otherwise, pc <= next_pc. Latency is 1 cycle from inputs to pc.
- Branch encoding (3 bits):
  - 0 JMP_NONE: next_pc = pc+4.
  - 1 JMP_JAL: next_pc = pc+pc_offset, unconditional.
  - 2 JMP_JALR: next_pc = {target_pc[XLEN-1:1],1'b0}. Bit 0 is cleared.
  - 3 JMP_BEQ: taken if alu_zero=1.
  - 4 JMP_BNE: taken if alu_zero=0.
  - 5 JMP_BLT: taken if alu_neg=1.
  - 6 JMP_BGT: taken if alu_neg=0. This implements the RISC-V BGE semantics (rs1 >= rs2).
  - 7 reserved: treated as JMP_NONE.
- Conditional branches: taken gives next_pc = pc+pc_offset; not taken gives pc+4.
- Arithmetic:
  - All additions are modulo 2^XLEN; wrap-around is silent.
  - pc_offset is already sign-extended and is added as two's complement.
- Combinational outputs:
  - return_pc = pc+4, purely combinational from pc, valid in every branch type.
  - next_pc is purely combinational from the inputs; no internal state besides pc.
- X-safety: if branch_type is unknown in simulation, next_pc defaults to pc+4 (default case).
- Flag handling: alu_zero and alu_neg are ignored for JMP_NONE, JAL, and JALR.

Decomposition:
- Shared package (controls_pkg): JMP_* localparams (3-bit) and the XLEN default.
- One combinational sub-module, branch_resolve:
  - Inputs: branch_type, alu_zero, alu_neg.
  - Outputs: take_rel (use pc+pc_offset) and take_abs (use target_pc).
- pc_calc contains the adders, next-PC mux, PC register and return_pc.

Test Plan:
- Reset and sequential fetch: rstn=1 for one edge, then rstn=0 with branch_type=JMP_NONE.
  - Required: pc=0, 4, 8 on successive edges.
  - Required: return_pc = pc+4 at each step.
- JAL: at pc=8 with pc_offset=12 and JMP_JAL, pc=20 next edge (and 32 if held one more cycle).
- Conditional branches, with pc_offset=12:
  - JMP_BEQ with alu_zero=1: pc advances by 12.
  - JMP_BNE with alu_zero=1: pc advances by 4.
  - JMP_BLT with alu_neg=1: pc advances by 12.
  - JMP_BGT with alu_neg=1: pc advances by 4.
  - JMP_BGT with alu_neg=0: pc advances by 12.
- JALR: target_pc=32'hAD with JMP_JALR gives pc=32'hAC next edge. alu flag values have no effect.
- Stall and reset priority:
  - stay=1 for 3 cycles: pc is constant.
  - stay=1 together with rstn=1: pc=RESET_PC.
  - Reset asserted mid-stream with JMP_JAL: pc=0.
- Wrap-around:
  - pc=32'hFFFF_FFFC with JMP_NONE gives pc=0.
  - pc_offset=32'hFFFF_FFF8 (-8) at pc=16 with JMP_JAL gives pc=8.
